// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register/word types, ALU opcodes and the ID/EX payload.
package cpu_types_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 4;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    // Everything the ID/EX register carries into EX.
    typedef struct packed {
        logic     valid;
        regbits_t rs;
        regbits_t rt;
        regbits_t wsel;
        logic     reg_write;
        logic     mem_read;
        logic     mem_write;
        logic     mem_to_reg;
        logic     alu_src;
        logic     halt;
        aluop_t   aluop;
        word_t    rdat1;
        word_t    rdat2;
        word_t    imm;
        word_t    pc4;
    } idex_t;

    // Reset and bubble share this single all-zero encoding.
    localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the EX-stage load and the ID instruction.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_valid,
    input  logic     ex_mem_read,
    input  regbits_t ex_wsel,
    input  logic     id_valid,
    input  regbits_t rs,
    input  regbits_t rt,
    input  logic     uses_rt,
    input  logic     flush,
    output logic     load_use_c,
    output logic     stall_c
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (ex_wsel == rs);
    assign rt_hit = uses_rt && (ex_wsel == rt);

    // A load targeting $0 never produces a dependency.
    assign load_use_c = ex_valid && ex_mem_read && (ex_wsel != '0) && id_valid
                        && (rs_hit || rt_hit);

    // A flushed ID instruction is discarded upstream, so it must not hold the front end.
    assign stall_c = load_use_c && !flush;

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush handling.
// Optional saturating stall/bubble counters are built when IDEX_PERF_CNT_EN is defined.
module idex_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     en,
    input  logic     flush,
    input  logic     id_valid,
    input  regbits_t rs_in,
    input  regbits_t rt_in,
    input  logic     uses_rt_in,
    input  regbits_t wsel_in,
    input  logic     RegWrite_in,
    input  logic     MemRead_in,
    input  logic     MemWrite_in,
    input  logic     MemToReg_in,
    input  logic     ALUSrc_in,
    input  logic     halt_in,
    input  aluop_t   aluop_in,
    input  word_t    rdat1_in,
    input  word_t    rdat2_in,
    input  word_t    imm_in,
    input  word_t    pc4_in,
    output regbits_t rs_out_2,
    output regbits_t rt_out_2,
    output regbits_t wsel_out_2,
    output logic     RegWrite_out_2,
    output logic     MemRead_out_2,
    output logic     MemWrite_out_2,
    output logic     MemToReg_out_2,
    output logic     ALUSrc_out_2,
    output logic     halt_out_2,
    output aluop_t   aluop_out_2,
    output word_t    rdat1_out_2,
    output word_t    rdat2_out_2,
    output word_t    imm_out_2,
    output word_t    pc4_out_2,
    output logic     valid_out_2,
    output logic     stall_id
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    idex_t q;
    idex_t d;
    logic  load_use;
    logic  stall_c;
    logic  bubble;

    load_use_detect u_load_use_detect (
        .ex_valid    (q.valid),
        .ex_mem_read (q.mem_read),
        .ex_wsel     (q.wsel),
        .id_valid    (id_valid),
        .rs          (rs_in),
        .rt          (rt_in),
        .uses_rt     (uses_rt_in),
        .flush       (flush),
        .load_use_c  (load_use),
        .stall_c     (stall_c)
    );

    assign stall_id = stall_c;
    assign bubble   = flush || load_use;

    // Next-state: hold when stalled by en, bubble on flush/load-use, else capture ID.
    always_comb begin
        d = q;
        if (en) begin
            if (bubble) begin
                d = IDEX_BUBBLE;
            end else begin
                d.valid      = id_valid;
                d.rs         = rs_in;
                d.rt         = rt_in;
                d.wsel       = wsel_in;
                d.reg_write  = RegWrite_in && id_valid;
                d.mem_read   = MemRead_in  && id_valid;
                d.mem_write  = MemWrite_in && id_valid;
                d.mem_to_reg = MemToReg_in && id_valid;
                d.alu_src    = ALUSrc_in   && id_valid;
                d.halt       = halt_in     && id_valid;
                d.aluop      = aluop_in;
                d.rdat1      = rdat1_in;
                d.rdat2      = rdat2_in;
                d.imm        = imm_in;
                d.pc4        = pc4_in;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= IDEX_BUBBLE;
        end else begin
            q <= d;
        end
    end

    assign rs_out_2       = q.rs;
    assign rt_out_2       = q.rt;
    assign wsel_out_2     = q.wsel;
    assign RegWrite_out_2 = q.reg_write;
    assign MemRead_out_2  = q.mem_read;
    assign MemWrite_out_2 = q.mem_write;
    assign MemToReg_out_2 = q.mem_to_reg;
    assign ALUSrc_out_2   = q.alu_src;
    assign halt_out_2     = q.halt;
    assign aluop_out_2    = q.aluop;
    assign rdat1_out_2    = q.rdat1;
    assign rdat2_out_2    = q.rdat2;
    assign imm_out_2      = q.imm;
    assign pc4_out_2      = q.pc4;
    assign valid_out_2    = q.valid;

`ifdef IDEX_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating event counters, advanced only on cycles the pipeline moves.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (en) begin
            if (stall_c && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bubble && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage: directed hazard scenarios plus randomized traffic
// compared every cycle against a behavioural model of the ID/EX register.
module tb_idex_stage;
    import cpu_types_pkg::*;

`ifdef IDEX_PERF_CNT_EN
    localparam int unsigned TB_CNT_W = 4;
`else
    localparam int unsigned TB_CNT_W = 16;
`endif
    localparam int CNT_SAT = (1 << TB_CNT_W) - 1;

    logic     CLK, nRST, en, flush, id_valid, uses_rt_in;
    regbits_t rs_in, rt_in, wsel_in;
    logic     RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in, halt_in;
    aluop_t   aluop_in;
    word_t    rdat1_in, rdat2_in, imm_in, pc4_in;
    regbits_t rs_out_2, rt_out_2, wsel_out_2;
    logic     RegWrite_out_2, MemRead_out_2, MemWrite_out_2, MemToReg_out_2, ALUSrc_out_2, halt_out_2;
    aluop_t   aluop_out_2;
    word_t    rdat1_out_2, rdat2_out_2, imm_out_2, pc4_out_2;
    logic     valid_out_2, stall_id;
`ifdef IDEX_PERF_CNT_EN
    logic [TB_CNT_W-1:0] stall_cnt, bubble_cnt;
`endif

    idex_stage #(.CNT_W(TB_CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .id_valid(id_valid),
        .rs_in(rs_in), .rt_in(rt_in), .uses_rt_in(uses_rt_in), .wsel_in(wsel_in),
        .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemToReg_in(MemToReg_in), .ALUSrc_in(ALUSrc_in), .halt_in(halt_in),
        .aluop_in(aluop_in), .rdat1_in(rdat1_in), .rdat2_in(rdat2_in), .imm_in(imm_in),
        .pc4_in(pc4_in), .rs_out_2(rs_out_2), .rt_out_2(rt_out_2), .wsel_out_2(wsel_out_2),
        .RegWrite_out_2(RegWrite_out_2), .MemRead_out_2(MemRead_out_2),
        .MemWrite_out_2(MemWrite_out_2), .MemToReg_out_2(MemToReg_out_2),
        .ALUSrc_out_2(ALUSrc_out_2), .halt_out_2(halt_out_2), .aluop_out_2(aluop_out_2),
        .rdat1_out_2(rdat1_out_2), .rdat2_out_2(rdat2_out_2), .imm_out_2(imm_out_2),
        .pc4_out_2(pc4_out_2), .valid_out_2(valid_out_2), .stall_id(stall_id)
`ifdef IDEX_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what EX should hold, plus expected counter values.
    logic     m_valid, m_rw, m_mr, m_mw, m_m2r, m_as, m_halt;
    regbits_t m_rs, m_rt, m_wsel;
    aluop_t   m_aluop;
    word_t    m_rdat1, m_rdat2, m_imm, m_pc4;
    int       m_stall_cnt, m_bubble_cnt;

    function automatic bit model_load_use();
        return m_valid && m_mr && (m_wsel != 5'd0) && id_valid &&
               ((m_wsel == rs_in) || (uses_rt_in && (m_wsel == rt_in)));
    endfunction

    task automatic model_clear();
        {m_valid, m_rw, m_mr, m_mw, m_m2r, m_as, m_halt} = '0;
        m_rs = '0; m_rt = '0; m_wsel = '0; m_aluop = ALU_SLL;
        m_rdat1 = '0; m_rdat2 = '0; m_imm = '0; m_pc4 = '0;
    endtask

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            model_clear();
            m_stall_cnt  = 0;
            m_bubble_cnt = 0;
        end else if (en) begin
            bit lu;
            lu = model_load_use();
            if (lu && !flush && m_stall_cnt < CNT_SAT) m_stall_cnt++;
            if ((lu || flush) && m_bubble_cnt < CNT_SAT) m_bubble_cnt++;
            if (lu || flush) begin
                model_clear();
            end else begin
                m_valid = id_valid;
                m_rs = rs_in; m_rt = rt_in; m_wsel = wsel_in;
                m_rw = RegWrite_in & id_valid; m_mr = MemRead_in & id_valid;
                m_mw = MemWrite_in & id_valid; m_m2r = MemToReg_in & id_valid;
                m_as = ALUSrc_in & id_valid;   m_halt = halt_in & id_valid;
                m_aluop = aluop_in;
                m_rdat1 = rdat1_in; m_rdat2 = rdat2_in; m_imm = imm_in; m_pc4 = pc4_in;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (chk_on) begin
            check("valid_out_2", 32'(valid_out_2), 32'(m_valid));
            check("rs_out_2", 32'(rs_out_2), 32'(m_rs));
            check("rt_out_2", 32'(rt_out_2), 32'(m_rt));
            check("wsel_out_2", 32'(wsel_out_2), 32'(m_wsel));
            check("ctrl_out_2", 32'({RegWrite_out_2, MemRead_out_2, MemWrite_out_2,
                                     MemToReg_out_2, ALUSrc_out_2, halt_out_2}),
                  32'({m_rw, m_mr, m_mw, m_m2r, m_as, m_halt}));
            check("aluop_out_2", 32'(aluop_out_2), 32'(m_aluop));
            check("rdat1_out_2", rdat1_out_2, m_rdat1);
            check("rdat2_out_2", rdat2_out_2, m_rdat2);
            check("imm_out_2", imm_out_2, m_imm);
            check("pc4_out_2", pc4_out_2, m_pc4);
            check("stall_id", 32'(stall_id), 32'(model_load_use() && !flush));
`ifdef IDEX_PERF_CNT_EN
            check("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
            check("bubble_cnt", 32'(bubble_cnt), 32'(m_bubble_cnt));
`endif
        end
    end

    task automatic set_idle();
        en = 1'b1; flush = 1'b0; id_valid = 1'b0; uses_rt_in = 1'b0;
        rs_in = '0; rt_in = '0; wsel_in = '0;
        {RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in, halt_in} = '0;
        aluop_in = ALU_SLL; rdat1_in = '0; rdat2_in = '0; imm_in = '0; pc4_in = '0;
    endtask

    task automatic set_lw(input regbits_t dst);
        set_idle();
        id_valid = 1'b1; RegWrite_in = 1'b1; MemRead_in = 1'b1; MemToReg_in = 1'b1;
        ALUSrc_in = 1'b1; aluop_in = ALU_ADD; wsel_in = dst; rs_in = 5'd29; imm_in = 32'h10;
    endtask

    function automatic regbits_t pick_reg();
        case ($urandom_range(0, 4))
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            3:       return 5'd10;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic randomize_inputs();
        en = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 7) == 0);
        id_valid = ($urandom_range(0, 7) != 0);
        uses_rt_in = 1'($urandom);
        rs_in = pick_reg(); rt_in = pick_reg(); wsel_in = pick_reg();
        RegWrite_in = 1'($urandom); MemRead_in = ($urandom_range(0, 2) == 0);
        MemWrite_in = 1'($urandom); MemToReg_in = 1'($urandom);
        ALUSrc_in = 1'($urandom); halt_in = ($urandom_range(0, 15) == 0);
        aluop_in = aluop_t'(4'($urandom_range(0, 9)));
        rdat1_in = $urandom; rdat2_in = $urandom; imm_in = $urandom; pc4_in = $urandom;
    endtask

    task automatic next_cycle();
        @(posedge CLK); #1;
    endtask

    initial begin
        nRST = 1'b0;
        set_idle();
        #1 chk_on = 1'b1;

        // Reset held while inputs toggle.
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            randomize_inputs();
            en = 1'b1;
        end
        @(negedge CLK);
        check("reset_valid", 32'(valid_out_2), 32'd0);
        check("reset_stall", 32'(stall_id), 32'd0);
        check("reset_rdat1", rdat1_out_2, 32'd0);
        next_cycle();
        nRST = 1'b1;

        // Pass-through of a simple register-write instruction.
        set_idle();
        id_valid = 1'b1; rs_in = 5'd8; rt_in = 5'd9; wsel_in = 5'd10; RegWrite_in = 1'b1;
        uses_rt_in = 1'b1; aluop_in = ALU_ADD; rdat1_in = 32'h1234; pc4_in = 32'h404;
        next_cycle();
        set_idle();
        @(negedge CLK);
        check("pass_rs", 32'(rs_out_2), 32'd8);
        check("pass_rt", 32'(rt_out_2), 32'd9);
        check("pass_wsel", 32'(wsel_out_2), 32'd10);
        check("pass_regwrite", 32'(RegWrite_out_2), 32'd1);
        check("pass_valid", 32'(valid_out_2), 32'd1);
        check("pass_rdat1", rdat1_out_2, 32'h1234);

        // Load-use: lw $8 then add using $8.
        next_cycle();
        set_lw(5'd8);
        next_cycle();
        set_idle();
        id_valid = 1'b1; rs_in = 5'd8; rt_in = 5'd9; uses_rt_in = 1'b1;
        wsel_in = 5'd11; RegWrite_in = 1'b1; aluop_in = ALU_ADD;
        @(negedge CLK);
        check("lu_stall", 32'(stall_id), 32'd1);
        next_cycle();
        @(negedge CLK);
        check("lu_bubble_valid", 32'(valid_out_2), 32'd0);
        check("lu_bubble_memread", 32'(MemRead_out_2), 32'd0);
        check("lu_stall_released", 32'(stall_id), 32'd0);
        next_cycle();
        set_idle();
        @(negedge CLK);
        check("lu_add_rs", 32'(rs_out_2), 32'd8);
        check("lu_add_wsel", 32'(wsel_out_2), 32'd11);
        check("lu_add_valid", 32'(valid_out_2), 32'd1);

        // Load into $0 never stalls.
        next_cycle();
        set_lw(5'd0);
        next_cycle();
        set_idle();
        id_valid = 1'b1; rs_in = 5'd0; rt_in = 5'd0; uses_rt_in = 1'b1;
        @(negedge CLK);
        check("lw_zero_nostall", 32'(stall_id), 32'd0);

        // rt match only counts when the instruction reads rt; sw data dependency stalls.
        next_cycle();
        set_lw(5'd8);
        next_cycle();
        set_idle();
        id_valid = 1'b1; rs_in = 5'd3; rt_in = 5'd8; uses_rt_in = 1'b0;
        @(negedge CLK);
        check("rt_unused_nostall", 32'(stall_id), 32'd0);
        #1 uses_rt_in = 1'b1; MemWrite_in = 1'b1; ALUSrc_in = 1'b1;
        #1 check("sw_rt_stall", 32'(stall_id), 32'd1);

        // Flush coincident with load-use: no stall, bubble latched.
        next_cycle();
        set_lw(5'd8);
        next_cycle();
        set_idle();
        id_valid = 1'b1; rs_in = 5'd8; flush = 1'b1;
        @(negedge CLK);
        check("flush_nostall", 32'(stall_id), 32'd0);
        next_cycle();
        set_idle();
        @(negedge CLK);
        check("flush_bubble_valid", 32'(valid_out_2), 32'd0);
        check("flush_bubble_wsel", 32'(wsel_out_2), 32'd0);

        // en=0 during load-use freezes everything, stall keeps asserting.
        next_cycle();
        set_lw(5'd8);
        next_cycle();
        set_idle();
        id_valid = 1'b1; rs_in = 5'd8; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("hold_stall", 32'(stall_id), 32'd1);
            check("hold_wsel", 32'(wsel_out_2), 32'd8);
            next_cycle();
        end
        en = 1'b1;
        next_cycle();
        set_idle();

        // Reset asserted mid-stall clears outputs and drops the stall at once.
        next_cycle();
        set_lw(5'd9);
        next_cycle();
        set_idle();
        id_valid = 1'b1; rs_in = 5'd9;
        @(negedge CLK);
        #2 nRST = 1'b0;
        #1 check("rst_mid_valid", 32'(valid_out_2), 32'd0);
        check("rst_mid_stall", 32'(stall_id), 32'd0);
        next_cycle();
        nRST = 1'b1;
        set_idle();

        // Self-dependent lw held in ID: alternating stall/capture drives counters to saturation.
        next_cycle();
        set_lw(5'd8);
        rs_in = 5'd8;
        for (int i = 0; i < 40; i++) next_cycle();
        set_idle();
        @(negedge CLK);
`ifdef IDEX_PERF_CNT_EN
        check("stall_cnt_sat", 32'(stall_cnt), 32'(CNT_SAT));
        check("bubble_cnt_sat", 32'(bubble_cnt), 32'(CNT_SAT));
`endif

        // Randomized traffic, with one asynchronous reset pulse mid-run.
        for (int i = 0; i < 1500; i++) begin
            next_cycle();
            randomize_inputs();
            if (i == 700) begin
                #1 nRST = 1'b0;
                #1 nRST = 1'b1;
            end
        end
        next_cycle();
        set_idle();
        @(negedge CLK);
        #1 chk_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
